// File: rtl/sc_fir_pkg.sv
// Shared types and constants for the stochastic FIR sequencer.
// Holds the FSM enum, tap array type and Galois LFSR masks.
package sc_fir_pkg;

  localparam int N     = 11;
  localparam int ORDER = 9;
  localparam int POW2N = 1 << N;

  typedef enum logic [1:0] {
    IDLE,
    START,
    RUN,
    HOLD
  } seq_state_t;

  typedef logic [ORDER:0][N:0] tap_arr_t;

  // Right-shift Galois toggle masks, maximal length per width.
  function automatic logic [31:0] lfsr_taps(input int n);
    logic [31:0] m;
    case (n)
      3:       m = 32'h0006;
      4:       m = 32'h000C;
      5:       m = 32'h0014;
      6:       m = 32'h0030;
      7:       m = 32'h0060;
      8:       m = 32'h00B8;
      9:       m = 32'h0110;
      10:      m = 32'h0240;
      11:      m = 32'h0500;
      12:      m = 32'h0E08;
      13:      m = 32'h1C80;
      14:      m = 32'h3802;
      15:      m = 32'h6000;
      16:      m = 32'hB400;
      default: m = 32'h0500;
    endcase
    return m;
  endfunction

  localparam logic [31:0] LFSR_TAPS = lfsr_taps(N);

endpackage

// File: rtl/sc_lfsr.sv
// Right-shift Galois LFSR with synchronous load and enable.
// Reset and load both restore the seed, so the state never reaches 0.
module sc_lfsr #(
  parameter int           W    = 11,
  parameter logic [W-1:0] TAPS = '0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic         enable,
  input  logic [W-1:0] seed,
  output logic [W-1:0] state
);

  logic [W-1:0] state_q;
  logic [W-1:0] state_d;

  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = seed;
    end else if (enable) begin
      state_d = (state_q >> 1) ^ (state_q[0] ? TAPS : '0);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= seed;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/sc_fir_sequencer.sv
// Window sequencer for the stochastic FIR HWA datapath.
// Define SC_FIR_RNG_RESEED_EN to reload the LFSR at every window start.
module sc_fir_sequencer #(
  parameter int N     = 11,
  parameter int ORDER = 9,
  parameter int SEED  = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N:0]           in_sample,
  output logic [ORDER:0][N:0]  tap,
  output logic                 hwa_start,
  output logic [N-1:0]         sel_bits,
  output logic [N-1:0]         R_y,
  input  logic [N:0]           hwa_out,
  input  logic                 hwa_done,
  output logic                 y_valid,
  input  logic                 y_ready,
  output logic [N:0]           y_data,
  output logic                 busy
);

  import sc_fir_pkg::*;

  localparam logic [N-1:0] SEED_V  = N'(SEED);
  localparam logic [N-1:0] TAPS_V  = N'(lfsr_taps(N));
  localparam logic [N-1:0] SEL_MAX = '1;

`ifdef SC_FIR_RNG_RESEED_EN
  localparam logic RESEED = 1'b1;
`else
  localparam logic RESEED = 1'b0;
`endif

  seq_state_t          state_q, state_d;
  logic [ORDER:0][N:0] tap_q, tap_d;
  logic [N-1:0]        sel_q, sel_d;
  logic [N:0]          y_q, y_d;
  logic                lfsr_load;
  logic                lfsr_en;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      tap_q   <= '0;
      sel_q   <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      tap_q   <= tap_d;
      sel_q   <= sel_d;
      y_q     <= y_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tap_d   = tap_q;
    sel_d   = sel_q;
    y_d     = y_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          tap_d   = {tap_q[ORDER-1:0], in_sample};
          state_d = START;
        end
      end
      START: begin
        sel_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        // sel at its last value forces capture if done never arrives
        if (hwa_done || sel_q == SEL_MAX) begin
          y_d     = hwa_out;
          sel_d   = '0;
          state_d = HOLD;
        end else begin
          sel_d = sel_q + 1'b1;
        end
      end
      HOLD: begin
        if (y_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    hwa_start = 1'b1;
    busy      = 1'b0;
    y_valid   = 1'b0;
    lfsr_load = 1'b0;
    lfsr_en   = 1'b0;
    unique case (state_q)
      IDLE:  in_ready = 1'b1;
      START: begin
        busy      = 1'b1;
        lfsr_load = RESEED;
      end
      RUN: begin
        busy      = 1'b1;
        hwa_start = 1'b0;
        lfsr_en   = 1'b1;
      end
      HOLD:  y_valid = 1'b1;
      default: ;
    endcase
  end

  sc_lfsr #(
    .W    (N),
    .TAPS (TAPS_V)
  ) u_lfsr (
    .clock  (clock),
    .reset  (reset),
    .load   (lfsr_load),
    .enable (lfsr_en),
    .seed   (SEED_V),
    .state  (R_y)
  );

  assign tap      = tap_q;
  assign sel_bits = sel_q;
  assign y_data   = y_q;

endmodule

// File: tb/tb_sc_fir_sequencer.sv
// Self-checking bench for sc_fir_sequencer with an HWA counting stub.
// Optional SC_FIR_RNG_RESEED_EN changes the expected LFSR trace.
module tb_sc_fir_sequencer;
  import sc_fir_pkg::*;

  localparam int           SEED = 1;
  localparam logic [N-1:0] POLY = 11'h500;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [N:0]    in_sample = '0;
  tap_arr_t      tap;
  logic          hwa_start;
  logic [N-1:0]  sel_bits;
  logic [N-1:0]  R_y;
  logic [N:0]    hwa_out;
  logic          hwa_done;
  logic          y_valid;
  logic          y_ready = 1'b0;
  logic [N:0]    y_data;
  logic          busy;

  int tests = 0;
  int fails = 0;

  sc_fir_sequencer #(
    .N(N), .ORDER(ORDER), .SEED(SEED)
  ) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sample(in_sample), .tap(tap),
    .hwa_start(hwa_start), .sel_bits(sel_bits),
    .R_y(R_y), .hwa_out(hwa_out), .hwa_done(hwa_done),
    .y_valid(y_valid), .y_ready(y_ready),
    .y_data(y_data), .busy(busy)
  );

  always #5 clock = ~clock;

  // HWA stub: accumulator cleared by start, +1 per RUN cycle
  logic [N:0]   acc = '0;
  logic [N-1:0] done_at = '1;
  logic         done_en = 1'b1;
  logic         noise = 1'b0;

  always @(posedge clock) acc <= hwa_start ? '0 : acc + 1'b1;
  always @(negedge clock) noise = ($urandom_range(0, 3) == 0);
  assign hwa_out  = acc;
  assign hwa_done = (done_en && sel_bits == done_at) || (noise && !busy);

  function automatic logic [N-1:0] step(input logic [N-1:0] s);
    return s[0] ? ((s >> 1) ^ POLY) : (s >> 1);
  endfunction

  function automatic logic [N-1:0] adv(input logic [N-1:0] s, input longint k);
    logic [N-1:0] r = s;
    for (longint i = 0; i < k; i++) r = step(r);
    return r;
  endfunction

  // Reference model: 0 idle, 1 start, 2 run, 3 hold
  int           m_mode = 0;
  int           m_sel = 0;
  logic [N-1:0] m_lfsr = N'(SEED);
  tap_arr_t     m_tap = '0;
  logic [N:0]   m_y = '0;
  longint       m_runs = 0;
  longint       edge_n = 0;
  longint       acc_log[$];

  always @(posedge clock) begin
    edge_n++;
    if (reset) begin
      m_mode = 0; m_sel = 0; m_lfsr = N'(SEED);
      m_tap = '0; m_y = '0; m_runs = 0;
    end else begin
      case (m_mode)
        0: if (in_valid) begin
          m_tap = {m_tap[ORDER-1:0], in_sample};
          m_mode = 1;
          acc_log.push_back(edge_n);
        end
        1: begin
          m_mode = 2;
          m_sel = 0;
`ifdef SC_FIR_RNG_RESEED_EN
          m_lfsr = N'(SEED);
`endif
        end
        2: begin
          m_lfsr = step(m_lfsr);
          m_runs++;
          if ((done_en && N'(m_sel) == done_at) || m_sel == POW2N - 1) begin
            m_y = (N+1)'(m_sel);
            m_sel = 0;
            m_mode = 3;
          end else begin
            m_sel++;
          end
        end
        default: if (y_ready) m_mode = 0;
      endcase
    end
  end

  always @(negedge clock) begin : cmp
    logic [N-1:0] first_r;
    tests++;
    if (in_ready !== (m_mode == 0) || hwa_start !== (m_mode != 2) ||
        busy !== (m_mode == 1 || m_mode == 2) || y_valid !== (m_mode == 3) ||
        sel_bits !== N'(m_sel) || R_y !== m_lfsr || y_data !== m_y ||
        tap !== m_tap || R_y == '0) begin
      fails++;
      $display("FAIL cycle_%0d: rdy/st/busy/yv=%b%b%b%b sel=%0d R_y=%h y=%h tap=%h required %b%b%b%b sel=%0d R_y=%h y=%h tap=%h",
               edge_n, in_ready, hwa_start, busy, y_valid, sel_bits, R_y,
               y_data, tap, m_mode == 0, m_mode != 2,
               m_mode == 1 || m_mode == 2, m_mode == 3, m_sel, m_lfsr, m_y, m_tap);
    end
    if (m_mode == 2 && m_sel == 0) begin
`ifdef SC_FIR_RNG_RESEED_EN
      first_r = N'(SEED);
`else
      first_r = adv(N'(SEED), m_runs);
`endif
      tests++;
      if (R_y !== first_r) begin
        fails++;
        $display("FAIL window_first_R_y: got %h required %h", R_y, first_r);
      end
    end
  end

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clock);
  endtask

  task automatic push(input logic [N:0] s);
    int g = 0;
    in_valid = 1'b1;
    in_sample = s;
    while (!in_ready && g < 5000) begin
      tick(); g++;
    end
    if (!in_ready) check("push_timeout", 128'(in_ready), 128'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_yv();
    int g = 0;
    while (!y_valid && g < 5000) begin
      tick(); g++;
    end
    check("wait_y_valid", 128'(y_valid), 128'd1);
  endtask

  task automatic wait_idle();
    int g = 0;
    while (!in_ready && g < 5000) begin
      tick(); g++;
    end
    check("wait_idle", 128'(in_ready), 128'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick();
  endtask

  initial begin : wdog
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [N:0]   hy;
    logic [N-1:0] hs, hr;
    tap_arr_t     ht;
    logic [N-1:0] s;
    int           per, n0, g, yv_seen;

    // pin the LFSR model
    check("model_step_1", 128'(step(11'h001)), 128'h500);
    check("model_step_500", 128'(step(11'h500)), 128'h280);
    s = N'(SEED); per = 0;
    do begin s = step(s); per++; end while (s != N'(SEED) && per < 5000);
    check("model_period", 128'(per), 128'd2047);

    do_reset();
    check("rst_in_ready", 128'(in_ready), 128'd1);
    check("rst_hwa_start", 128'(hwa_start), 128'd1);
    check("rst_y_valid", 128'(y_valid), 128'd0);
    check("rst_R_y", 128'(R_y), 128'(SEED));
    check("rst_tap", 128'(tap), 128'd0);

    // single window with done at the last count, then backpressure
    done_en = 1'b1; done_at = '1; y_ready = 1'b0;
    push(12'h155);
    wait_yv();
    check("latency", 128'(edge_n - acc_log[$]), 128'(POW2N + 1));
    check("y_data_2047", 128'(y_data), 128'd2047);
    check("tap0_155", 128'(tap[0]), 128'h155);
    hy = y_data; hs = sel_bits; hr = R_y; ht = tap;
    for (int i = 0; i < 100; i++) begin
      in_valid = ($urandom_range(0, 1) == 1);
      in_sample = (N+1)'($urandom);
      tick();
      check("hold_stable", {y_data, sel_bits, R_y, in_ready, tap},
            {hy, hs, hr, 1'b0, ht});
    end
    in_valid = 1'b0;

    // release with a simultaneous sample: taken in the next IDLE cycle
    done_at = N'($urandom_range(0, 1500));
    y_ready = 1'b1;
    push(12'h2AB);
    check("tap0_2ab", 128'(tap[0]), 128'h2AB);
    check("tap1_155", 128'(tap[1]), 128'h155);
    wait_idle();

    // tap shifting over three windows
    do_reset();
    for (int k = 1; k <= 3; k++) begin
      done_at = N'($urandom_range(0, 300));
      push((N+1)'(k));
    end
    check("tap_0to2", 128'({tap[0], tap[1], tap[2]}), 128'({12'd3, 12'd2, 12'd1}));
    check("tap_3to9", 128'(tap[ORDER:3]), 128'd0);
    wait_idle();

    // back-to-back windows on the self-timed fallback
    done_en = 1'b0;
    n0 = acc_log.size();
    in_valid = 1'b1;
    g = 0;
    while (acc_log.size() < n0 + 3 && g < 8000) begin
      in_sample = (N+1)'($urandom);
      tick(); g++;
    end
    in_valid = 1'b0;
    check("b2b_accepts", 128'(acc_log.size()), 128'(n0 + 3));
    if (acc_log.size() >= 2)
      check("throughput", 128'(acc_log[$] - acc_log[acc_log.size() - 2]),
            128'(POW2N + 3));
    wait_idle();

    // reset in the middle of a window
    push((N+1)'($urandom));
    g = 0;
    while (sel_bits != 11'd500 && g < 3000) begin
      tick(); g++;
    end
    check("reach_sel_500", 128'(sel_bits), 128'd500);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrun_rst_idle", 128'({in_ready, busy, y_valid}), 128'b100);
    check("midrun_rst_sel", 128'(sel_bits), 128'd0);
    yv_seen = 0;
    for (int i = 0; i < 2100; i++) begin
      tick();
      if (y_valid) yv_seen++;
    end
    check("no_y_valid_after_rst", 128'(yv_seen), 128'd0);

    // randomized windows
    y_ready = 1'b0;
    for (int w = 0; w < 4; w++) begin
      done_en = ($urandom_range(0, 3) != 0);
      done_at = N'($urandom);
      tick($urandom_range(0, 5));
      push((N+1)'($urandom));
      wait_yv();
      tick($urandom_range(0, 20));
      y_ready = 1'b1;
      tick();
      y_ready = 1'b0;
    end
    tick(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
